// File: rtl/pcie_datalink_pkg.sv
// Shared PCIe data-link definitions: link state encoding, DLLP type codes and
// helpers that build the single-beat DLLP word.
package pcie_datalink_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_FEATURE  = 2'd1,
        DL_INIT     = 2'd2,
        DL_ACTIVE   = 2'd3
    } pcie_dl_status_e;

    localparam logic [7:0] DLLP_ACK      = 8'h00;
    localparam logic [7:0] DLLP_NAK      = 8'h10;
    localparam logic [7:0] DLLP_UPDFC_P  = 8'h80;
    localparam logic [7:0] DLLP_UPDFC_NP = 8'h90;

    // The 24-bit field goes out most-significant byte first after the type byte.
    function automatic logic [31:0] dllp_pack(input logic [7:0] dllp_type, input logic [23:0] field);
        return {field[7:0], field[15:8], field[23:16], dllp_type};
    endfunction

    function automatic logic [23:0] fc_field(input logic [7:0] hdr_fc, input logic [11:0] data_fc);
        return {2'b00, hdr_fc, 2'b00, data_fc};
    endfunction

endpackage

// File: rtl/dllp_tx_scheduler.sv
// DLLP transmit scheduler: tracks Ack/Nak/UpdateFC requests and emits one
// single-beat DLLP at a time on an AXI-Stream toward the phy.
module dllp_tx_scheduler
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 4,
    parameter int ACK_LATENCY = 255,
    parameter int FC_PERIOD   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pcie_dl_status_e       link_status_i,
    input  logic                  ack_req_i,
    input  logic                  nak_req_i,
    input  logic [11:0]           rx_seq_i,
    input  logic                  fc_update_req_i,
    input  logic [7:0]            rx_fc_ph_i,
    input  logic [11:0]           rx_fc_pd_i,
    input  logic [7:0]            rx_fc_nph_i,
    input  logic [11:0]           rx_fc_npd_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int              FC_W    = (FC_PERIOD > 1) ? $clog2(FC_PERIOD) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FC_PERIOD - 1);
    localparam logic [15:0]     ACK_LAT = 16'(ACK_LATENCY);

    logic [0:0]      state_r;
    logic [7:0]      sel_type_r;
    logic            nak_pending_r;
    logic            nak_scheduled_r;
    logic            ack_pending_r;
    logic            fcp_pending_r;
    logic            fcnp_pending_r;
    logic [11:0]     seq_r;
    logic [15:0]     ack_cnt_r;
    logic [FC_W-1:0] fc_cnt_r;

    logic            link_up_s;
    logic            ack_due_s;
    logic            start_s;
    logic            accept_s;
    logic            ack_clear_s;
    logic            fc_expire_s;
    logic [7:0]      sel_type_s;
    logic [23:0]     sel_field_s;

    assign link_up_s   = (link_status_i == DL_ACTIVE);
    assign ack_due_s   = ack_pending_r && (ack_cnt_r >= ACK_LAT);
    assign start_s     = (state_r == ST_IDLE) && link_up_s &&
                         (nak_pending_r || ack_due_s || fcp_pending_r || fcnp_pending_r);
    assign accept_s    = (state_r == ST_SEND) && m_axis_tvalid && m_axis_tready;
    // A sent Nak also retires any outstanding Ack.
    assign ack_clear_s = accept_s && ((sel_type_r == DLLP_ACK) || (sel_type_r == DLLP_NAK));
    assign fc_expire_s = (fc_cnt_r == FC_LAST);

    // Priority selection of the next DLLP from registered pending flags
    always_comb begin
        sel_type_s  = DLLP_ACK;
        sel_field_s = 24'h000000;
        if (nak_pending_r) begin
            sel_type_s  = DLLP_NAK;
            sel_field_s = {12'h000, seq_r};
        end else if (ack_due_s) begin
            sel_type_s  = DLLP_ACK;
            sel_field_s = {12'h000, seq_r};
        end else if (fcp_pending_r) begin
            sel_type_s  = DLLP_UPDFC_P;
            sel_field_s = fc_field(rx_fc_ph_i, rx_fc_pd_i);
        end else if (fcnp_pending_r) begin
            sel_type_s  = DLLP_UPDFC_NP;
            sel_field_s = fc_field(rx_fc_nph_i, rx_fc_npd_i);
        end else begin
            sel_type_s  = DLLP_ACK;
            sel_field_s = 24'h000000;
        end
    end

    // Request bookkeeping; later statements win so a new request beats a same-cycle retire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nak_pending_r   <= 1'b0;
            nak_scheduled_r <= 1'b0;
            ack_pending_r   <= 1'b0;
            fcp_pending_r   <= 1'b0;
            fcnp_pending_r  <= 1'b0;
            seq_r           <= 12'h000;
            ack_cnt_r       <= 16'h0000;
            fc_cnt_r        <= {FC_W{1'b0}};
        end else if (!link_up_s) begin
            nak_pending_r   <= 1'b0;
            nak_scheduled_r <= 1'b0;
            ack_pending_r   <= 1'b0;
            fcp_pending_r   <= 1'b0;
            fcnp_pending_r  <= 1'b0;
            seq_r           <= 12'h000;
            ack_cnt_r       <= 16'h0000;
            fc_cnt_r        <= {FC_W{1'b0}};
        end else begin
            if (fc_expire_s) begin
                fc_cnt_r <= {FC_W{1'b0}};
            end else begin
                fc_cnt_r <= fc_cnt_r + FC_W'(1);
            end
            if (accept_s && (sel_type_r == DLLP_UPDFC_P)) begin
                fcp_pending_r <= 1'b0;
            end
            if (accept_s && (sel_type_r == DLLP_UPDFC_NP)) begin
                fcnp_pending_r <= 1'b0;
            end
            if (fc_update_req_i || fc_expire_s) begin
                fcp_pending_r  <= 1'b1;
                fcnp_pending_r <= 1'b1;
            end

            if (ack_clear_s) begin
                ack_pending_r <= 1'b0;
                ack_cnt_r     <= 16'h0000;
            end else if (ack_pending_r && (ack_cnt_r < ACK_LAT)) begin
                ack_cnt_r <= ack_cnt_r + 16'd1;
            end
            if (accept_s && (sel_type_r == DLLP_NAK)) begin
                nak_pending_r <= 1'b0;
            end

            // The latency window starts at the first Ack request, not the most recent one.
            if (ack_req_i) begin
                ack_pending_r   <= 1'b1;
                seq_r           <= rx_seq_i;
                nak_scheduled_r <= 1'b0;
                if (!ack_pending_r || ack_clear_s) begin
                    ack_cnt_r <= 16'd1;
                end
            end
            if (nak_req_i) begin
                seq_r <= rx_seq_i;
                if (!nak_scheduled_r) begin
                    nak_pending_r   <= 1'b1;
                    nak_scheduled_r <= 1'b1;
                end
            end
        end
    end

    // Output beat register: loaded on IDLE->SEND and held until the phy accepts it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            sel_type_r    <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= {DATA_WIDTH{1'b0}};
            m_axis_tkeep  <= {KEEP_WIDTH{1'b0}};
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= {USER_WIDTH{1'b0}};
        end else if (start_s) begin
            state_r       <= ST_SEND;
            sel_type_r    <= sel_type_s;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= dllp_pack(sel_type_s, sel_field_s);
            m_axis_tkeep  <= {KEEP_WIDTH{1'b1}};
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= {{(USER_WIDTH-1){1'b0}}, 1'b1};
        end else if (accept_s) begin
            state_r       <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Directed bench for dllp_tx_scheduler with short Ack latency and FC period.
module tb_dllp_tx_scheduler;
    import pcie_datalink_pkg::*;

    localparam int ACK_LAT = 20;
    localparam int FC_PER  = 300;

    logic            clk = 1'b0;
    logic            rst_n;
    pcie_dl_status_e link;
    logic            ack_req, nak_req, fc_req, tready;
    logic [11:0]     rx_seq;
    logic [7:0]      fc_ph, fc_nph;
    logic [11:0]     fc_pd, fc_npd;
    logic [31:0]     tdata;
    logic [3:0]      tkeep, tuser;
    logic            tvalid, tlast;

    int total = 0;
    int bad   = 0;
    logic [31:0] sent_q[$];

    dllp_tx_scheduler #(
        .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4),
        .ACK_LATENCY(ACK_LAT), .FC_PERIOD(FC_PER)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .link_status_i(link),
        .ack_req_i(ack_req), .nak_req_i(nak_req), .rx_seq_i(rx_seq),
        .fc_update_req_i(fc_req),
        .rx_fc_ph_i(fc_ph), .rx_fc_pd_i(fc_pd), .rx_fc_nph_i(fc_nph), .rx_fc_npd_i(fc_npd),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .m_axis_tready(tready)
    );

    always #5 clk = ~clk;

    // Record every beat that will be accepted at the coming rising edge
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) sent_q.push_back(tdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        ack_req = 1'b0; nak_req = 1'b0; fc_req = 1'b0; tready = 1'b1;
        link = DL_INACTIVE;
        repeat (3) step();
        link = DL_ACTIVE;
        sent_q.delete();
    endtask

    task automatic test_reset();
        #2;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", tvalid); end
        total++; if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", tdata); end
        total++; if ({tkeep, tuser, tlast} !== 9'h000) begin bad++; $display("FAIL reset_side got=%h/%h/%b want=0", tkeep, tuser, tlast); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ack();
        int seen;
        quiesce();
        rx_seq = 12'h005; ack_req = 1'b1; step(); ack_req = 1'b0;
        seen = 0;
        for (int k = 1; k <= 60; k++) begin step(); if (tvalid) begin seen = k; break; end end
        total++; if (seen !== ACK_LAT) begin bad++; $display("FAIL ack_latency got=%0d want=%0d", seen, ACK_LAT); end
        total++; if (tdata !== 32'h0500_0000) begin bad++; $display("FAIL ack_tdata got=%h want=05000000", tdata); end
        total++; if (tkeep !== 4'hF || tlast !== 1'b1 || tuser !== 4'h1) begin bad++; $display("FAIL ack_side got=%h/%b/%h want=f/1/1", tkeep, tlast, tuser); end
        // new request lands on the acceptance edge and must not be lost
        rx_seq = 12'h077; ack_req = 1'b1; step(); ack_req = 1'b0;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ack_drop got=%0b want=0", tvalid); end
        seen = 0;
        for (int k = 1; k <= 60; k++) begin step(); if (tvalid) begin seen = k; break; end end
        total++; if (seen !== ACK_LAT) begin bad++; $display("FAIL ack_rearm_latency got=%0d want=%0d", seen, ACK_LAT); end
        total++; if (tdata !== 32'h7700_0000) begin bad++; $display("FAIL ack_rearm_tdata got=%h want=77000000", tdata); end
        step();
    endtask

    task automatic test_nak();
        quiesce();
        rx_seq = 12'hABC; nak_req = 1'b1; step();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL nak_early got=%0b want=0", tvalid); end
        step();
        total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL nak_latency got=%0b want=1", tvalid); end
        total++; if (tdata !== 32'hBC0A_0010) begin bad++; $display("FAIL nak_tdata got=%h want=bc0a0010", tdata); end
        nak_req = 1'b0; rx_seq = 12'h123; ack_req = 1'b1; step();
        ack_req = 1'b0; rx_seq = 12'h124; nak_req = 1'b1; step();
        nak_req = 1'b0;
        repeat (40) step();
        total++; if (sent_q.size() !== 2) begin bad++; $display("FAIL nak_count got=%0d want=2", sent_q.size()); end
        if (sent_q.size() == 2) begin
            total++; if (sent_q[0] !== 32'hBC0A_0010) begin bad++; $display("FAIL nak_first got=%h want=bc0a0010", sent_q[0]); end
            total++; if (sent_q[1] !== 32'h2401_0010) begin bad++; $display("FAIL nak_second got=%h want=24010010", sent_q[1]); end
        end
    endtask

    task automatic test_fc();
        quiesce();
        fc_ph = 8'h20; fc_pd = 12'h080; fc_nph = 8'h05; fc_npd = 12'h010;
        fc_req = 1'b1; step(); fc_req = 1'b0;
        step();
        total++; if (tvalid !== 1'b1 || tdata !== 32'h8000_0880) begin bad++; $display("FAIL fcp_beat got=%b/%h want=1/80000880", tvalid, tdata); end
        fc_nph = 8'h06; fc_ph = 8'h33;
        step();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL fcp_accept got=%0b want=0", tvalid); end
        step();
        total++; if (tvalid !== 1'b1 || tdata !== 32'h1080_0190) begin bad++; $display("FAIL fcnp_beat got=%b/%h want=1/10800190", tvalid, tdata); end
        step();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL fcnp_accept got=%0b want=0", tvalid); end
    endtask

    task automatic test_stall();
        int unstable;
        quiesce();
        tready = 1'b0;
        rx_seq = 12'h011; ack_req = 1'b1; step(); ack_req = 1'b0;
        repeat (14) step();
        rx_seq = 12'h012; nak_req = 1'b1; step(); nak_req = 1'b0;
        step();
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (tvalid !== 1'b1 || tdata !== 32'h1200_0010) unstable++;
            step();
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles want=0", unstable); end
        tready = 1'b1;
        repeat (40) step();
        total++; if (sent_q.size() !== 1) begin bad++; $display("FAIL stall_count got=%0d want=1", sent_q.size()); end
        if (sent_q.size() >= 1) begin
            total++; if (sent_q[0] !== 32'h1200_0010) begin bad++; $display("FAIL stall_nak got=%h want=12000010", sent_q[0]); end
        end
    endtask

    task automatic test_link_drop();
        quiesce();
        rx_seq = 12'h033; ack_req = 1'b1; step(); ack_req = 1'b0;
        repeat (5) step();
        link = DL_INIT;
        repeat (3) step();
        link = DL_ACTIVE;
        repeat (40) step();
        total++; if (sent_q.size() !== 0) begin bad++; $display("FAIL link_drop got=%0d beats want=0", sent_q.size()); end
    endtask

    task automatic test_fc_periodic();
        int seen;
        fc_ph = 8'h01; fc_pd = 12'h002; fc_nph = 8'h03; fc_npd = 12'h004;
        quiesce();
        seen = 0;
        for (int k = 1; k <= 400; k++) begin step(); if (tvalid) begin seen = k; break; end end
        total++; if (seen !== FC_PER + 1) begin bad++; $display("FAIL fc_period got=%0d want=%0d", seen, FC_PER + 1); end
        total++; if (tdata !== 32'h0240_0080) begin bad++; $display("FAIL fc_period_p got=%h want=02400080", tdata); end
        step(); step();
        total++; if (tvalid !== 1'b1 || tdata !== 32'h04C0_0090) begin bad++; $display("FAIL fc_period_np got=%b/%h want=1/04c00090", tvalid, tdata); end
        step();
    endtask

    task automatic test_reset_mid_send();
        quiesce();
        tready = 1'b0;
        rx_seq = 12'h055; nak_req = 1'b1; step(); nak_req = 1'b0;
        step();
        total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0b want=1", tvalid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b want=0", tvalid); end
        total++; if ({tdata, tkeep, tuser, tlast} !== 41'h0) begin bad++; $display("FAIL rst_outputs got=%h/%h/%h/%b want=0", tdata, tkeep, tuser, tlast); end
        step();
        rst_n = 1'b1;
        tready = 1'b1;
        repeat (5) step();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_after got=%0b want=0", tvalid); end
    endtask

    initial begin
        rst_n = 1'b0; link = DL_INACTIVE;
        ack_req = 1'b0; nak_req = 1'b0; fc_req = 1'b0; tready = 1'b1;
        rx_seq = 12'h000; fc_ph = 8'h00; fc_pd = 12'h000; fc_nph = 8'h00; fc_npd = 12'h000;
        test_reset();
        test_ack();
        test_nak();
        test_fc();
        test_stall();
        test_link_drop();
        test_fc_periodic();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
